// File: rtl/audipus_pkg.sv
// rtl/audipus_pkg.sv - shared button-input constants and long-press FSM encoding
//
// Purpose : constants shared by the button debouncer files.
//   lp_state_t      2-bit long-press FSM state type
//   LP_IDLE/DOWN/HELD  FSM states: released / held, timing / long event issued
//   BTN_ACTIVE_LOW  board buttons use pull-ups, so a pressed pin reads 0
package audipus_pkg;

    typedef logic [1:0] lp_state_t;

    localparam logic [1:0] LP_IDLE = 2'd0;
    localparam logic [1:0] LP_DOWN = 2'd1;
    localparam logic [1:0] LP_HELD = 2'd2;

    localparam bit BTN_ACTIVE_LOW = 1'b1;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button channel: synchroniser, debounce, event pulses, long-press FSM
//
// Purpose : conditions a single raw button pin.
// Ports   :
//   clk          in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   btn_raw      in   asynchronous raw pin
//   btn_level    out  debounced level, 1 = pressed
//   btn_press    out  1-cycle pulse when btn_level rises
//   btn_release  out  1-cycle pulse when btn_level falls
//   btn_long     out  1-cycle pulse LONG_CYCLES cycles after btn_press
module debounce_channel
    import audipus_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter bit ACTIVE_LOW      = BTN_ACTIVE_LOW
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic              sync_ff1;
    logic              sync_ff2;
    logic              sync;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    lp_state_t         lp_state;
    logic              accept;

    // Synchronised pin with polarity normalised: 1 = pressed.
    assign sync   = sync_ff2 ^ ACTIVE_LOW;

    // The level flips on the edge that completes DEBOUNCE_CYCLES consecutive
    // disagreeing samples.
    assign accept = (sync != btn_level) && (db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Synchroniser loads the released pin value so a button held
            // through reset is seen as a fresh press afterwards.
            sync_ff1    <= ACTIVE_LOW;
            sync_ff2    <= ACTIVE_LOW;
            db_cnt      <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;
            hold_cnt    <= '0;
            lp_state    <= LP_IDLE;
        end else begin
            sync_ff1    <= btn_raw;
            sync_ff2    <= sync_ff1;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;

            if (sync == btn_level) begin
                db_cnt <= '0;
            end else if (accept) begin
                btn_level   <= sync;
                db_cnt      <= '0;
                btn_press   <= sync;
                btn_release <= ~sync;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end

            // The FSM keys off the accept condition rather than the registered
            // press pulse so btn_long lands exactly LONG_CYCLES after btn_press.
            case (lp_state)
                LP_IDLE: begin
                    if (accept && sync) begin
                        lp_state <= LP_DOWN;
                        hold_cnt <= '0;
                    end
                end
                LP_DOWN: begin
                    if (accept && !sync) begin
                        // Release wins over a long event due on the same edge.
                        lp_state <= LP_IDLE;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        btn_long <= 1'b1;
                        lp_state <= LP_HELD;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                LP_HELD: begin
                    if (accept && !sync) begin
                        lp_state <= LP_IDLE;
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    lp_state <= LP_IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - debounced levels and press/release/long events for board push-buttons
//
// Purpose : NUM_BTN independent debounce channels between the button pins
//           and the control logic.
// Ports   :
//   clk          in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   btn_raw      in   [NUM_BTN] asynchronous raw button pins
//   btn_level    out  [NUM_BTN] debounced level, 1 = pressed
//   btn_press    out  [NUM_BTN] 1-cycle pulse when btn_level rises
//   btn_release  out  [NUM_BTN] 1-cycle pulse when btn_level falls
//   btn_long     out  [NUM_BTN] 1-cycle pulse when held LONG_CYCLES past press
module button_debouncer
    import audipus_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter bit ACTIVE_LOW      = BTN_ACTIVE_LOW
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_long    (btn_long[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer
module tb_button_debouncer;

    localparam int NB = 4;
    localparam int D  = 8;
    localparam int L  = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_long;

    button_debouncer #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: per channel, a history of normalised pin samples (bit k =
    // sample taken k edges ago). The level toggles when the D samples that
    // have made it through the 2-stage synchroniser all disagree with it.
    bit [D+1:0]    hist [NB];
    bit [NB-1:0]   m_level, m_press, m_rel, m_long;
    int            press_t [NB];
    int            t = 0;

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        t++;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        if (!reset_n) begin
            m_level = '0;
            for (int c = 0; c < NB; c++) hist[c] = '0;
        end else begin
            for (int c = 0; c < NB; c++) begin
                bit [D-1:0] win;
                hist[c] = {hist[c][D:0], ~btn_raw[c]};
                win = hist[c][D+1:2];
                if (win == (m_level[c] ? {D{1'b0}} : {D{1'b1}})) begin
                    m_level[c] = ~m_level[c];
                    if (m_level[c]) begin
                        m_press[c] = 1'b1;
                        press_t[c] = t;
                    end else begin
                        m_rel[c] = 1'b1;
                    end
                end else if (m_level[c] && (t - press_t[c] == L)) begin
                    m_long[c] = 1'b1;
                end
            end
        end
        @(negedge clk);
        chk("level",   btn_level,   m_level);
        chk("press",   btn_press,   m_press);
        chk("release", btn_release, m_rel);
        chk("long",    btn_long,    m_long);
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int c = 0; c < NB; c++) begin
            hist[c]    = '0;
            press_t[c] = 0;
        end
        m_level = '0;
        reset_n = 1'b0;
        btn_raw = 4'hF;

        // 1: reset, then idle with all buttons released
        tickn(3);
        chk("reset_level", btn_level | btn_press | btn_release | btn_long, 4'h0);
        reset_n = 1'b1;
        tickn(100);
        chk("idle_outputs", btn_level | btn_press | btn_release | btn_long, 4'h0);

        // 2: single clean press on bit 0
        btn_raw[0] = 1'b0;
        tickn(9);
        chk("s2_before", btn_level, 4'b0000);
        tick();
        chk("s2_press", btn_press, 4'b0001);
        chk("s2_level", btn_level, 4'b0001);
        tickn(40);
        btn_raw[0] = 1'b1;
        tickn(60);

        // 3: bouncing bit 1, then held
        for (int i = 0; i < 4; i++) begin
            btn_raw[1] = ~btn_raw[1];
            tickn(5);
        end
        btn_raw[1] = 1'b0;
        tickn(9);
        chk("s3_before", btn_level, 4'b0000);
        tick();
        chk("s3_press", btn_press, 4'b0010);
        tickn(50);
        btn_raw[1] = 1'b1;
        tickn(30);

        // 4: long press on bit 2
        btn_raw[2] = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 10) chk("s4_press", btn_press, 4'b0100);
            if (i == 42) chk("s4_long", btn_long, 4'b0100);
        end
        btn_raw[2] = 1'b1;
        tickn(9);
        chk("s4_still_held", btn_level, 4'b0100);
        tick();
        chk("s4_release", btn_release, 4'b0100);
        tickn(40);

        // 5: simultaneous press on bits 0 and 3
        btn_raw[0] = 1'b0;
        btn_raw[3] = 1'b0;
        tickn(10);
        chk("s5_press", btn_press, 4'b1001);
        tickn(20);
        btn_raw = 4'hF;
        tickn(40);

        // 6: reset while bit 0 is held
        btn_raw[0] = 1'b0;
        tickn(20);
        chk("s6_pre_reset", btn_level, 4'b0001);
        reset_n = 1'b0;
        tickn(2);
        chk("s6_in_reset", btn_level | btn_press | btn_release | btn_long, 4'h0);
        reset_n = 1'b1;
        tickn(9);
        chk("s6_before", btn_level, 4'b0000);
        tick();
        chk("s6_repress", btn_press, 4'b0001);
        tickn(40);
        btn_raw = 4'hF;
        tickn(40);

        // Randomised bouncing/holding on all channels with occasional resets
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < NB; c++)
                if ($urandom_range(11) == 0) btn_raw[c] = ~btn_raw[c];
            reset_n = ($urandom_range(399) != 0);
            tick();
        end
        reset_n = 1'b1;
        tickn(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
